// File: rtl/uart_ctrl.sv
// Bus-side UART controller: TX byte FIFO feeding a start/busy handshake FSM,
// a single-byte RX holding register, and three memory-mapped words (TXD/RXD/CON).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no frame in progress; launches the FIFO head when non-empty
// START     | tx_start high for one cycle, FIFO head popped at cycle end
// WAIT_BUSY | waiting for the TX core to raise tx_busy
// WAIT_DONE | frame shifting; completion (tx_done) flagged when busy drops
module uart_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h40000018,
    parameter int          TX_DEPTH  = 4
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        irq
);

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         fifo_q [TX_DEPTH];
    logic [7:0]         fifo_d [TX_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_done_q, tx_done_d;
    logic               tx_ovr_q, tx_ovr_d;
    logic [7:0]         rx_buf_q, rx_buf_d;
    logic               rx_full_q, rx_full_d;
    logic               rx_ovr_q, rx_ovr_d;
    logic               tx_ie_q, tx_ie_d;
    logic               rx_ie_q, rx_ie_d;
    logic               irq_q, irq_d;

    logic txd_hit, rxd_hit, con_hit;
    logic wr_txd, wr_con, rd_rxd, rd_con;
    logic fifo_full, fifo_empty, pending;
    logic push_ok, pop, done_set;
    logic unused_wdata;

    assign txd_hit = (addr == BASE_ADDR);
    assign rxd_hit = (addr == BASE_ADDR + 32'd4);
    assign con_hit = (addr == BASE_ADDR + 32'd8);

    assign wr_txd = wr & txd_hit;
    assign wr_con = wr & con_hit;
    assign rd_rxd = rd & rxd_hit;
    assign rd_con = rd & con_hit;

    assign fifo_full  = (cnt_q == CNT_W'(TX_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign pending    = ~fifo_empty | (state_q != IDLE);

    // The head slot is freed in START, so a push while full is accepted then.
    assign pop     = (state_q == START);
    assign push_ok = wr_txd & (~fifo_full | pop);

    assign unused_wdata = ^wdata[31:8];

    always_comb begin
        fifo_d = fifo_q;
        if (push_ok) begin
            fifo_d[wr_ptr_q] = wdata[7:0];
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
    end

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        done_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d    = START;
                    tx_start_d = 1'b1;
                    tx_data_d  = fifo_q[rd_ptr_q];
                end
            end
            START: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky flags: a new event on the same edge as a clearing read is kept.
    always_comb begin
        tx_done_d = (tx_done_q & ~rd_con) | done_set;
        tx_ovr_d  = (tx_ovr_q & ~rd_con) | (wr_txd & fifo_full & ~pop);
        rx_buf_d  = rx_buf_q;
        rx_full_d = rx_full_q;
        rx_ovr_d  = rx_ovr_q & ~rd_con;
        if (rx_valid) begin
            rx_buf_d  = rx_byte;
            rx_full_d = 1'b1;
            if (rx_full_q && !rd_rxd) begin
                rx_ovr_d = 1'b1;
            end
        end else if (rd_rxd) begin
            rx_full_d = 1'b0;
        end
        tx_ie_d = wr_con ? wdata[0] : tx_ie_q;
        rx_ie_d = wr_con ? wdata[1] : rx_ie_q;
        irq_d   = (tx_ie_q & tx_done_q) | (rx_ie_q & rx_full_q);
    end

    always_comb begin
        rdata = 32'd0;
        if (rd_rxd) begin
            rdata = {24'd0, rx_buf_q};
        end else if (rd_con) begin
            rdata = {24'd0, rx_ovr_q, tx_ovr_q, pending, fifo_full,
                     rx_full_q, tx_done_q, rx_ie_q, tx_ie_q};
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_done_q  <= 1'b0;
            tx_ovr_q   <= 1'b0;
            rx_buf_q   <= 8'd0;
            rx_full_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_ie_q    <= 1'b0;
            rx_ie_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            tx_done_q  <= tx_done_d;
            tx_ovr_q   <= tx_ovr_d;
            rx_buf_q   <= rx_buf_d;
            rx_full_q  <= rx_full_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_ie_q    <= tx_ie_d;
            rx_ie_q    <= rx_ie_d;
            irq_q      <= irq_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed and randomized checks of uart_ctrl against a queue/flag-level model
// of the register map, TX FIFO ordering and RX holding-register rules.
module tb_uart_ctrl;

    localparam logic [31:0] TXD   = 32'h40000018;
    localparam logic [31:0] RXD   = 32'h4000001C;
    localparam logic [31:0] CON   = 32'h40000020;
    localparam int          DEPTH = 4;

    logic        sysclk;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        irq;

    logic        manual_busy;
    logic        auto_busy;
    int          core_cnt;
    int          cyc;
    int          total;
    int          bad;
    logic [7:0]  sent_q[$];
    int          start_cyc[$];

    uart_ctrl #(.BASE_ADDR(TXD), .TX_DEPTH(DEPTH)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .irq      (irq)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    assign tx_busy = manual_busy | (core_cnt != 0);

    // Stand-in TX core: busy for three cycles after each accepted start.
    always @(posedge sysclk or negedge reset) begin
        if (!reset) core_cnt <= 0;
        else if (auto_busy && tx_start) core_cnt <= 3;
        else if (core_cnt != 0) core_cnt <= core_cnt - 1;
    end

    always @(posedge sysclk) begin
        cyc <= cyc + 1;
        if (reset && tx_start) begin
            sent_q.push_back(tx_data);
            start_cyc.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sysclk);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0; addr = 32'd0; wdata = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        #1 d = rdata;
        tick();
        rd = 1'b0; addr = 32'd0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_byte = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_sent(input int target, input string tag);
        for (int t = 0; t < 300 && sent_q.size() < target; t++) tick();
        chk(tag, 32'(sent_q.size()), 32'(target));
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  exp_q[$];
        int          n;
        logic [7:0]  m_buf;
        logic        m_full, m_ovr;
        logic [1:0]  m_ie;

        total = 0; bad = 0; cyc = 0;
        reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
        rx_valid = 1'b0; rx_byte = 8'd0; manual_busy = 1'b0; auto_busy = 1'b0;
        repeat (3) tick();
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        bus_read(CON, d); chk("rst_con", d, 32'd0);
        reset = 1'b1;
        tick();

        // single byte latency and tx_done
        bus_write(TXD, 32'h0000_000F);
        chk("lat_k1_start", 32'(tx_start), 32'd0);
        tick();
        chk("lat_k2_start", 32'(tx_start), 32'd1);
        chk("lat_k2_data", 32'(tx_data), 32'h0F);
        tick();
        chk("lat_k3_start", 32'(tx_start), 32'd0);
        chk("lat_data_hold", 32'(tx_data), 32'h0F);
        manual_busy = 1'b1;
        repeat (10) tick();
        manual_busy = 1'b0;
        repeat (2) tick();
        bus_read(CON, d); chk("done_set", d, 32'h04);
        bus_read(CON, d); chk("done_clr", d, 32'h00);
        bus_read(TXD, d); chk("txd_read", d, 32'h00);

        // fill FIFO behind an in-flight byte, overflow, then same-edge push/pop while full
        manual_busy = 1'b1;
        for (int i = 0; i < 6; i++) bus_write(TXD, 32'h31 + 32'(i));
        repeat (2) tick();
        bus_read(CON, d); chk("full_con", d, 32'h70);
        chk("full_inflight", 32'(sent_q.size()), 32'd2);
        manual_busy = 1'b0; auto_busy = 1'b1;
        for (int t = 0; t < 50 && tx_start !== 1'b1; t++) tick();
        chk("pp_start_seen", 32'(tx_start), 32'd1);
        chk("pp_head", 32'(tx_data), 32'h32);
        bus_write(TXD, 32'h37);
        wait_sent(7, "pp_count");
        exp_q = '{8'h0F, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h37};
        for (int i = 1; i < 7; i++) begin
            chk($sformatf("order_%0d", i), 32'(sent_q[i]), 32'(exp_q[i]));
            chk($sformatf("gap_%0d", i), 32'(start_cyc[i] - start_cyc[i-1] >= 2), 32'd1);
        end
        repeat (12) tick();
        bus_read(CON, d); chk("pp_no_ovr", d, 32'h04);

        // RX interrupt
        bus_write(CON, 32'h2);
        rx_pulse(8'hA5);
        repeat (2) tick();
        chk("rx_irq_on", 32'(irq), 32'd1);
        bus_read(RXD, d); chk("rx_a5", d, 32'h0000_00A5);
        repeat (2) tick();
        chk("rx_irq_off", 32'(irq), 32'd0);

        // RX overrun and same-edge read/receive
        rx_pulse(8'h11);
        rx_pulse(8'h22);
        bus_read(RXD, d); chk("ovr_rxd", d, 32'h22);
        bus_read(CON, d); chk("ovr_con", d, 32'h82);
        bus_read(CON, d); chk("ovr_clr", d, 32'h02);
        rx_pulse(8'h44);
        addr = RXD; rd = 1'b1; rx_valid = 1'b1; rx_byte = 8'h33;
        #1 d = rdata;
        chk("same_old", d, 32'h44);
        tick();
        rd = 1'b0; rx_valid = 1'b0; addr = 32'd0;
        bus_read(CON, d); chk("same_con", d, 32'h0A);
        bus_read(RXD, d); chk("same_new", d, 32'h33);

        // reset while a frame is in flight with bytes queued
        auto_busy = 1'b0;
        repeat (6) tick();
        rx_pulse(8'h66);
        manual_busy = 1'b1;
        bus_write(TXD, 32'h71); bus_write(TXD, 32'h72); bus_write(TXD, 32'h73);
        repeat (4) tick();
        bus_read(CON, d); chk("pre_rst_con", d, 32'h2A);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        n = sent_q.size();
        reset = 1'b0;
        #1;
        chk("arst_start", 32'(tx_start), 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        chk("arst_data", 32'(tx_data), 32'd0);
        manual_busy = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (20) tick();
        chk("post_rst_quiet", 32'(sent_q.size()), 32'(n));
        bus_read(CON, d); chk("post_rst_con", d, 32'h00);
        bus_read(RXD, d); chk("post_rst_rxd", d, 32'h00);
        auto_busy = 1'b1;
        bus_write(TXD, 32'h5A);
        tick();
        chk("post_rst_start", 32'(tx_start), 32'd1);
        wait_sent(n + 1, "post_rst_count");
        chk("post_rst_byte", 32'(sent_q[n]), 32'h5A);
        repeat (12) tick();
        bus_read(CON, d); chk("post_rst_done", d, 32'h04);

        // randomized RX traffic against the flag model
        m_ie = 2'($urandom_range(0, 3));
        bus_write(CON, 32'(m_ie));
        m_buf = 8'd0; m_full = 1'b0; m_ovr = 1'b0;
        for (int i = 0; i < 80; i++) begin
            logic v, r_rxd, r_con;
            logic [7:0] b;
            int op;
            v = 1'($urandom_range(0, 1));
            b = 8'($urandom_range(0, 255));
            op = $urandom_range(0, 3);
            r_rxd = (op == 0);
            r_con = (op == 1) && !v;
            rx_valid = v; rx_byte = b;
            if (r_rxd) begin addr = RXD; rd = 1'b1; end
            if (r_con) begin addr = CON; rd = 1'b1; end
            #1;
            if (r_rxd) chk($sformatf("rnd_rxd_%0d", i), rdata, {24'd0, m_buf});
            if (r_con) chk($sformatf("rnd_con_%0d", i), rdata,
                           {24'd0, m_ovr, 3'b000, m_full, 1'b0, m_ie});
            tick();
            rx_valid = 1'b0; rd = 1'b0; addr = 32'd0;
            if (v) begin
                if (m_full && !r_rxd) m_ovr = 1'b1;
                m_buf = b; m_full = 1'b1;
            end else if (r_rxd) begin
                m_full = 1'b0;
            end
            if (r_con) m_ovr = 1'b0;
        end

        // randomized TX bursts: bytes must leave in write order
        for (int k = 0; k < 3; k++) begin
            int base, len;
            base = sent_q.size();
            len = $urandom_range(1, DEPTH);
            exp_q = {};
            for (int j = 0; j < len; j++) begin
                logic [7:0] b;
                b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
                bus_write(TXD, 32'(b));
                repeat ($urandom_range(0, 2)) tick();
            end
            wait_sent(base + len, $sformatf("burst%0d_count", k));
            for (int j = 0; j < len && base + j < sent_q.size(); j++)
                chk($sformatf("burst%0d_b%0d", k, j), 32'(sent_q[base + j]), 32'(exp_q[j]));
            repeat (12) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
